// File: rtl/seq_detect_param_pkg.sv
// Shared constants and width helper for the programmable serial pattern detector.
// Defaults describe the reset configuration: detect 0110 with overlap.
package seq_detect_pkg;

   localparam int PAT_W = 8;
   localparam int CNT_W = 16;

   function automatic int len_w(input int pat_w);
      return $clog2(pat_w + 1);
   endfunction

   localparam int LEN_W = $clog2(PAT_W + 1);

   localparam logic [PAT_W-1:0] RST_PAT = 8'b0000_0110;
   localparam int               RST_LEN = 4;
   localparam bit               RST_OVL = 1'b1;

endpackage

// File: rtl/seq_detect_param_if.sv
// Serial data, configuration and result signals of the pattern detector.
// The master side drives bits and config; the slave side is the detector.
interface seq_detect_param_if #(
   parameter int PAT_W = seq_detect_pkg::PAT_W,
   parameter int CNT_W = seq_detect_pkg::CNT_W
);
   localparam int LEN_W = seq_detect_pkg::len_w(PAT_W);

   logic             en;
   logic             x;
   logic             cfg_load;
   logic [PAT_W-1:0] cfg_pat;
   logic [LEN_W-1:0] cfg_len;
   logic             cfg_ovl;
   logic             cnt_clr;
   logic             z;
   logic [CNT_W-1:0] match_count;
   logic             cnt_sat;

   modport master (
      output en, x, cfg_load, cfg_pat, cfg_len, cfg_ovl, cnt_clr,
      input  z, match_count, cnt_sat
   );

   modport slave (
      input  en, x, cfg_load, cfg_pat, cfg_len, cfg_ovl, cnt_clr,
      output z, match_count, cnt_sat
   );

endinterface

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with synchronous clear and a registered all-ones flag.
// A clear coinciding with an increment leaves the count at 1.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count,
   output logic         sat
);

   logic [W-1:0] count_n;

   always_comb begin
      count_n = count;
      if (clr) begin
         count_n = inc ? W'(1) : '0;
      end else if (inc && !(&count)) begin
         count_n = count + W'(1);
      end
   end

   // sat is derived from the next value so it lines up with count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
         sat   <= 1'b0;
      end else begin
         count <= count_n;
         sat   <= &count_n;
      end
   end

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector with registered match pulse,
// overlap/non-overlap selection and a saturating match counter.
module seq_detect_param #(
   parameter int               PAT_W   = seq_detect_pkg::PAT_W,
   parameter int               CNT_W   = seq_detect_pkg::CNT_W,
   parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(seq_detect_pkg::RST_PAT),
   parameter int               RST_LEN = seq_detect_pkg::RST_LEN,
   parameter bit               RST_OVL = seq_detect_pkg::RST_OVL
) (
   input logic               clk,
   input logic               reset,
   seq_detect_param_if.slave bus
);

   localparam int               LEN_W    = seq_detect_pkg::len_w(PAT_W);
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);
   localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'((RST_LEN > PAT_W) ? PAT_W : RST_LEN);

   logic [PAT_W-1:0] hist;
   logic [PAT_W-1:0] hist_n;
   logic [PAT_W-1:0] pat_q;
   logic [PAT_W-1:0] mask;
   logic [LEN_W-1:0] fill;
   logic [LEN_W-1:0] fill_n;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] len_ld;
   logic             ovl_q;
   logic             match;
   logic             z_q;

   always_comb begin
      hist_n = {hist[PAT_W-2:0], bus.x};
      fill_n = (fill == LEN_MAX) ? fill : fill + LEN_W'(1);
      mask   = '0;
      for (int i = 0; i < PAT_W; i++) begin
         mask[i] = (LEN_W'(i) < len_q);
      end
      // a zero length leaves the mask empty but is still excluded explicitly
      match  = bus.en && !bus.cfg_load && (len_q != '0) && (fill_n >= len_q) &&
               (((hist_n ^ pat_q) & mask) == '0);
      len_ld = (bus.cfg_len > LEN_MAX) ? LEN_MAX : bus.cfg_len;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist  <= '0;
         fill  <= '0;
         z_q   <= 1'b0;
         pat_q <= RST_PAT;
         len_q <= LEN_INIT;
         ovl_q <= RST_OVL;
      end else if (bus.cfg_load) begin
         hist  <= '0;
         fill  <= '0;
         z_q   <= 1'b0;
         pat_q <= bus.cfg_pat;
         len_q <= len_ld;
         ovl_q <= bus.cfg_ovl;
      end else begin
         z_q <= match;
         if (bus.en) begin
            hist <= hist_n;
            fill <= (match && !ovl_q) ? '0 : fill_n;
         end
      end
   end

   assign bus.z = z_q;

   sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (match),
      .clr   (bus.cnt_clr),
      .count (bus.match_count),
      .sat   (bus.cnt_sat)
   );

endmodule
